alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, requester 0 and requester 1. Typical requesters are the execute stage and a background/microcode unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel. The block grants requesters round-robin.
- It latches the winner's operands, drives the ALU for exactly one cycle, registers the result and holds it until the owner accepts it.
- The block drives the ALU's reset input so the ALU output is forced to zero whenever no operation is executing.

Parameters:
- WORD_W, 16, operand/result width; equals the `WORD_VEC width.
- OPCODE_W, 4, opcode width; equals the `OPCODE_VEC width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: operation of requester i accepted this cycle.
- req_opcode0 / req_opcode1  input  OPCODE_W  opcode per requester.
- req_a0 / req_a1  input  WORD_W  operand A per requester.
- req_b0 / req_b1  input  WORD_W  operand B per requester.
- resp_valid  output  2  bit i: response for requester i is held.
- resp_ready  input  2  bit i: requester i takes its response.
- resp_data  output  WORD_W  registered ALU result (shared bus; qualified by resp_valid).
- resp_err  output  1  registered; opcode was not ADD/MOV/SUB/AND/OR/NOT.
- alu_a, alu_b  output  WORD_W  to ALU A/B; driven from operand registers.
- alu_opcode  output  OPCODE_W  to ALU opcode; driven from the opcode register.
- alu_reset  output  1  to ALU reset.
- alu_result  input  WORD_W  from ALU result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous, active-high.
- Reset values:
  - state = IDLE, prio = 0.
  - req_ready = 0, resp_valid = 0, resp_data = 0, resp_err = 0, busy = 0.
  - Operand, opcode and owner registers = 0.
  - alu_reset = 1.
- States: IDLE, EXEC, RESP.
- IDLE, grant:
  - Only one req_valid bit set: grant that requester.
  - Both set: grant requester prio.
  - req_ready[g] = 1 combinationally, in IDLE only. The other bit is 0.
- IDLE, accept edge (req_valid[g] & req_ready[g]):
  - Latch opcode/A/B of requester g and owner = g.
  - Go to EXEC.
- EXEC, exactly 1 cycle:
  - alu_reset = 0. ALU inputs are driven from the latched registers.
  - At the edge: resp_data <= alu_result.
  - resp_err <= 1 if the opcode is outside {`ADD, `MOV, `SUB, `AND, `OR, `NOT}. In that case resp_data holds the ALU's 0.
  - Go to RESP.
- alu_reset = 1 in IDLE and RESP.
- RESP:
  - resp_valid[owner] = 1; the other bit is 0.
  - resp_data and resp_err are stable while resp_valid is held.
  - On resp_ready[owner]: go to IDLE, prio <= ~owner, resp_valid drops next cycle.
  - resp_ready of the non-owner is ignored.
- Latency:
  - Accept at edge N.
  - resp_valid high in cycle after edge N+1 (two edges after the accept cycle).
  - Minimum initiation interval is 3 cycles (accept, EXEC, RESP with resp_ready=1).
- No new request is accepted until the response completes; req_ready = 0 in EXEC and RESP.
- Requesters must hold valid/opcode/operands stable until ready. Changes to the non-granted requester's inputs have no effect.
- Arithmetic: purely the ALU's. Results are WORD_W bits; carry/borrow are discarded and wrap modulo 2^WORD_W.
- Fairness: prio toggles only on response completion. A requester with continuous valid waits at most one foreign operation.
- Reset mid-operation (EXEC or RESP):
  - Immediate return to reset values.
  - The pending response is discarded and never presented.
  - prio = 0.

Test Plan:
- Single request: req0 ADD A=5 B=3 in IDLE -> req_ready[0]=1 that cycle; alu_reset=0 for one cycle; resp_valid[0]=1 two edges later with resp_data=8, resp_err=0; resp_ready[0]=1 -> busy=0 the next cycle.
- Contention after reset: both valid (req0 SUB 10-4, req1 AND 0xF0F0&0x00FF) -> req0 served first (resp_data=6); req1 then served (0x00F0). Then both valid again -> req0 served (prio returned to 0 after req1). Check strict alternation over 8 contended operations.
- Backpressure: req1 OR 0x1200|0x0034, resp_ready[1]=0 for 5 cycles -> resp_valid[1] and resp_data=0x1234 stable; req_ready=0 while req0 valid. Asserting resp_ready[0] during this time has no effect.
- Illegal opcode: req0 with an undefined encoding, A=7 B=9 -> resp_err=1, resp_data=0. Next op MOV 0+0x55 -> resp_err=0, resp_data=0x55.
- Wrap/NOT: SUB 0-1 -> 0xFFFF; NOT A=0x00FF -> 0xFF00; ADD 0xFFFF+2 -> 0x0001.
- Async reset mid-EXEC and mid-RESP: assert reset between clock edges -> all outputs go to reset values immediately without a clock edge. After release, no stale response is presented and the next contended grant goes to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// The winner of a round-robin grant has its opcode and operands latched. The
// ALU then runs for one cycle, and the result is registered and held until the
// owner accepts it. Outside the execute cycle the ALU is held in reset, so its
// output reads zero.
//
// Ports:
//   clk, reset                clock (rising edge); asynchronous active-high reset
//   req_valid/req_ready[1:0]  per-requester request handshake
//   req_opcode0/1, req_a0/1, req_b0/1   request payload per requester
//   resp_valid/resp_ready[1:0]          per-requester response handshake
//   resp_data, resp_err       registered result / illegal-opcode flag (shared)
//   alu_a, alu_b, alu_opcode  ALU inputs, driven from the latched registers
//   alu_reset                 ALU reset, low only during the execute cycle
//   alu_result                ALU output
//   busy                      high whenever an operation is in flight
module alu_arbiter #(
    parameter int WORD_W   = 16,
    parameter int OPCODE_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [OPCODE_W-1:0] req_opcode0,
    input  logic [OPCODE_W-1:0] req_opcode1,
    input  logic [WORD_W-1:0]   req_a0,
    input  logic [WORD_W-1:0]   req_a1,
    input  logic [WORD_W-1:0]   req_b0,
    input  logic [WORD_W-1:0]   req_b1,
    output logic [1:0]          resp_valid,
    input  logic [1:0]          resp_ready,
    output logic [WORD_W-1:0]   resp_data,
    output logic                resp_err,
    output logic [WORD_W-1:0]   alu_a,
    output logic [WORD_W-1:0]   alu_b,
    output logic [OPCODE_W-1:0] alu_opcode,
    output logic                alu_reset,
    input  logic [WORD_W-1:0]   alu_result,
    output logic                busy
);

    // Opcode encodings understood by the ALU.
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_OR  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_NOT = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_MOV = OPCODE_W'(5);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state, state_nx;
    logic                prio;
    logic                owner;
    logic                grant;
    logic [OPCODE_W-1:0] op_r;
    logic [WORD_W-1:0]   a_r, b_r;
    logic                illegal;

    assign alu_a      = a_r;
    assign alu_b      = b_r;
    assign alu_opcode = op_r;

    assign illegal = !(op_r inside {OP_ADD, OP_MOV, OP_SUB, OP_AND, OP_OR, OP_NOT});

    // A lone requester wins outright; under contention prio decides.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11)
            grant = prio;
        else if (req_valid == 2'b10)
            grant = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        alu_reset  = 1'b1;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                // Gated by reset so ready stays low while reset is held.
                if (|req_valid && !reset) begin
                    req_ready[grant] = 1'b1;
                    state_nx         = EXEC;
                end
            end
            EXEC: begin
                alu_reset = 1'b0;
                state_nx  = RESP;
            end
            RESP: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner])
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio      <= 1'b0;
            owner     <= 1'b0;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    owner <= grant;
                    op_r  <= grant ? req_opcode1 : req_opcode0;
                    a_r   <= grant ? req_a1 : req_a0;
                    b_r   <= grant ? req_b1 : req_b0;
                end
                EXEC: begin
                    // Illegal opcodes leave the ALU's zero in resp_data.
                    resp_data <= alu_result;
                    resp_err  <= illegal;
                end
                RESP: if (resp_ready[owner])
                    prio <= ~owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. A behavioural ALU drives alu_result.
// Expected values are hand-computed constants.
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_BAD = 4'd15;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [3:0]  req_opcode0, req_opcode1, alu_opcode;
    logic [15:0] req_a0, req_a1, req_b0, req_b1;
    logic [15:0] resp_data, alu_a, alu_b, alu_result;
    logic        resp_err, alu_reset, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WORD_W(16), .OPCODE_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode0(req_opcode0), .req_opcode1(req_opcode1),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_reset(alu_reset), .alu_result(alu_result), .busy(busy)
    );

    // External ALU: zero while in reset or for an unknown opcode.
    always_comb begin
        alu_result = 16'h0000;
        if (!alu_reset) begin
            case (alu_opcode)
                OP_ADD:  alu_result = alu_a + alu_b;
                OP_SUB:  alu_result = alu_a - alu_b;
                OP_AND:  alu_result = alu_a & alu_b;
                OP_OR:   alu_result = alu_a | alu_b;
                OP_NOT:  alu_result = ~alu_a;
                OP_MOV:  alu_result = alu_b;
                default: alu_result = 16'h0000;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        if (r == 0) begin
            req_opcode0 = op; req_a0 = a; req_b0 = b; req_valid[0] = 1'b1;
        end else begin
            req_opcode1 = op; req_a1 = a; req_b1 = b; req_valid[1] = 1'b1;
        end
    endtask

    // Runs one operation end to end. Requests must already be presented.
    task automatic serve(input string tag, input int own, input logic [15:0] data, input logic err);
        logic [1:0] onehot;
        onehot = (own == 0) ? 2'b01 : 2'b10;
        #1;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(onehot));
        @(posedge clk); #1;
        req_valid[own] = 1'b0;
        chk({tag, ".exec_alu_reset"}, 32'(alu_reset), 0);
        chk({tag, ".exec_ready"}, 32'(req_ready), 0);
        @(posedge clk); #1;
        chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(onehot));
        chk({tag, ".resp_data"}, 32'(resp_data), 32'(data));
        chk({tag, ".resp_err"}, 32'(resp_err), 32'(err));
        chk({tag, ".resp_alu_reset"}, 32'(alu_reset), 1);
        resp_ready[own] = 1'b1;
        @(posedge clk); #1;
        resp_ready[own] = 1'b0;
        chk({tag, ".busy_after"}, 32'(busy), 0);
        chk({tag, ".valid_after"}, 32'(resp_valid), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".resp_valid"}, 32'(resp_valid), 0);
        chk({tag, ".req_ready"}, 32'(req_ready), 0);
        chk({tag, ".resp_data"}, 32'(resp_data), 0);
        chk({tag, ".resp_err"}, 32'(resp_err), 0);
        chk({tag, ".alu_reset"}, 32'(alu_reset), 1);
        chk({tag, ".alu_a"}, 32'(alu_a), 0);
        chk({tag, ".alu_opcode"}, 32'(alu_opcode), 0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00; resp_ready = 2'b00;
        req_opcode0 = '0; req_opcode1 = '0;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        #2;
        check_reset_vals("por");
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Single request.
        set_req(0, OP_ADD, 16'd5, 16'd3);
        serve("single", 0, 16'd8, 1'b0);

        // Contention from reset: strict alternation starting with req0.
        reset = 1'b1; #1; reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            set_req(0, OP_SUB, 16'(10 + i), 16'd4);
            set_req(1, OP_AND, 16'hF0F0, 16'h00FF);
            serve($sformatf("rr%0d", i), i % 2, (i % 2 == 0) ? 16'(6 + i) : 16'h00F0, 1'b0);
        end
        req_valid = 2'b00;

        // Backpressure on req1, with req0 waiting and a stray resp_ready[0].
        set_req(1, OP_OR, 16'h1200, 16'h0034);
        #1;
        chk("bp.req_ready", 32'(req_ready), 2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        set_req(0, OP_ADD, 16'd1, 16'd2);
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp.resp_valid", 32'(resp_valid), 2);
            chk("bp.resp_data", 32'(resp_data), 32'h1234);
            chk("bp.req_ready", 32'(req_ready), 0);
            @(posedge clk); #1;
        end
        resp_ready = 2'b10;
        @(posedge clk); #1;
        resp_ready = 2'b00;
        chk("bp.busy_after", 32'(busy), 0);
        serve("bp.req0", 0, 16'd3, 1'b0);

        // Illegal opcode, then recovery.
        set_req(0, OP_BAD, 16'd7, 16'd9);
        serve("illegal", 0, 16'h0000, 1'b1);
        set_req(0, OP_MOV, 16'h0000, 16'h0055);
        serve("mov", 0, 16'h0055, 1'b0);

        // Wrap-around and NOT.
        set_req(1, OP_SUB, 16'h0000, 16'h0001);
        serve("sub_wrap", 1, 16'hFFFF, 1'b0);
        set_req(0, OP_NOT, 16'h00FF, 16'h0000);
        serve("not", 0, 16'hFF00, 1'b0);
        set_req(1, OP_ADD, 16'hFFFF, 16'h0002);
        serve("add_wrap", 1, 16'h0001, 1'b0);

        // Asynchronous reset during EXEC.
        set_req(0, OP_ADD, 16'd1, 16'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("mid_exec.busy", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check_reset_vals("mid_exec");
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("mid_exec.no_stale", 32'(resp_valid), 0);
        end

        // Leave prio at 1, then reset during req1's RESP.
        set_req(0, OP_ADD, 16'd2, 16'd2);
        serve("pre_resp", 0, 16'd4, 1'b0);
        set_req(1, OP_ADD, 16'h0010, 16'h0020);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        chk("mid_resp.valid_before", 32'(resp_valid), 2);
        chk("mid_resp.data_before", 32'(resp_data), 32'h0030);
        #2 reset = 1'b1;
        #1;
        check_reset_vals("mid_resp");
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("mid_resp.no_stale", 32'(resp_valid), 0);
        end
        set_req(0, OP_ADD, 16'd9, 16'd1);
        set_req(1, OP_ADD, 16'd7, 16'd1);
        serve("post_reset_grant", 0, 16'd10, 1'b0);
        req_valid = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Keeps the run finite if something upstream stalls.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got no finish, want finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
